// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO push-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_EMPTY,
      ARB_HOLD
   } arb_state_t;

   localparam int STALL_CNT_W = 16;

   // Pointer width for a requester index; never narrower than one bit.
   function automatic int ptr_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle of the push arbiter.
interface fifo_push_arbiter_if #(
   parameter int NUM_REQ        = 4,
   parameter int ELEM_SIZE_BITS = 96
);
   import fifo_arb_pkg::*;

   logic [NUM_REQ-1:0]                req;
   logic [NUM_REQ*ELEM_SIZE_BITS-1:0] req_data;
   logic                              flush;
   logic [NUM_REQ-1:0]                grant;
   logic [ELEM_SIZE_BITS-1:0]         fifo_in_data;
   logic                              fifo_pushing;
   logic                              fifo_push_must_wait;
   logic [STALL_CNT_W-1:0]            stall_count;

   modport master (
      input  req, req_data, flush, fifo_push_must_wait,
      output grant, fifo_in_data, fifo_pushing, stall_count
   );

   modport slave (
      output req, req_data, flush, fifo_push_must_wait,
      input  grant, fifo_in_data, fifo_pushing, stall_count
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               any
);

   logic [PTR_W-1:0] idx;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port; holds the winner's element under backpressure.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ELEM_SIZE_BITS = 96
) (
   input logic                 CLK,
   input logic                 RESET,
   fifo_push_arbiter_if.master bus
);

   localparam int PTR_W = ptr_w(NUM_REQ);

   arb_state_t                state;
   logic [PTR_W-1:0]          rr_ptr;
   logic [PTR_W-1:0]          winner;
   logic                      any;
   logic [NUM_REQ-1:0]        grant_q;
   logic [ELEM_SIZE_BITS-1:0] data_q;
   logic [STALL_CNT_W-1:0]    stall_q;
   logic [ELEM_SIZE_BITS-1:0] slice [NUM_REQ];
   logic                      accept;
   logic                      load;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slice[g] = bus.req_data[g*ELEM_SIZE_BITS +: ELEM_SIZE_BITS];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .any    (any)
   );

   // A load in the same edge as an accept refills the holding register with no bubble.
   assign accept = (state == ARB_HOLD) && !bus.fifo_push_must_wait;
   assign load   = (state == ARB_EMPTY) || accept;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= ARB_EMPTY;
         rr_ptr  <= '0;
         grant_q <= '0;
         data_q  <= '0;
         stall_q <= '0;
      end else begin
         grant_q <= '0;
         if (bus.flush) begin
            state  <= ARB_EMPTY;
            data_q <= '0;
         end else if (load) begin
            if (any) begin
               state   <= ARB_HOLD;
               data_q  <= slice[winner];
               grant_q <= NUM_REQ'(1) << winner;
               rr_ptr  <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
            end else begin
               state  <= ARB_EMPTY;
               data_q <= '0;
            end
         end
         if (state == ARB_HOLD && bus.fifo_push_must_wait && stall_q != '1)
            stall_q <= stall_q + STALL_CNT_W'(1);
      end
   end

   assign bus.grant        = grant_q;
   assign bus.fifo_in_data = data_q;
   assign bus.fifo_pushing = (state == ARB_HOLD);
   assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: rotation, wrap, backpressure, flush, reset and saturation.
module tb_fifo_push_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR = 4;
   localparam int EW = 96;

   logic CLK;
   logic RESET;
   int   checks = 0;
   int   fails  = 0;

   fifo_push_arbiter_if #(.NUM_REQ(NR), .ELEM_SIZE_BITS(EW)) bus ();

   fifo_push_arbiter #(.NUM_REQ(NR), .ELEM_SIZE_BITS(EW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_slice(input int i, input logic [EW-1:0] v);
      bus.req_data[i*EW +: EW] = v;
   endtask

   task automatic expect_out(input string name, input logic [NR-1:0] eg, input logic ep,
                             input logic [EW-1:0] ed);
      checks++;
      if (bus.grant !== eg || bus.fifo_pushing !== ep || bus.fifo_in_data !== ed) begin
         fails++;
         $display("FAIL %s: got grant=%b pushing=%b data=%h, expected grant=%b pushing=%b data=%h",
                  name, bus.grant, bus.fifo_pushing, bus.fifo_in_data, eg, ep, ed);
      end
   endtask

   task automatic expect_cnt(input string name, input logic [STALL_CNT_W-1:0] ec);
      checks++;
      if (bus.stall_count !== ec) begin
         fails++;
         $display("FAIL %s: got stall_count=%h expected %h", name, bus.stall_count, ec);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.req = '0;
      bus.flush = 1'b0;
      bus.fifo_push_must_wait = 1'b0;
      for (int i = 0; i < NR; i++) set_slice(i, EW'(32'h10 + i));
      #3;
      expect_out("reset_outputs", 4'b0000, 1'b0, '0);
      expect_cnt("reset_stall_count", 16'h0000);
      tick();
      RESET = 1'b1;
      tick();
      expect_out("idle_after_reset", 4'b0000, 1'b0, '0);
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int            ei [5] = '{0, 1, 2, 3, 0};
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out($sformatf("rr_cycle%0d", i), eg[i], 1'b1, EW'(32'h10 + ei[i]));
      end
      bus.req = '0;
      tick();
      expect_out("rr_drain", 4'b0000, 1'b0, '0);
   endtask

   // rr_ptr is 1 on entry; one grant to requester 1 moves it to 2.
   task automatic test_ptr_wrap();
      bus.req = 4'b0010;
      tick();
      expect_out("wrap_setup", 4'b0010, 1'b1, EW'(32'h11));
      bus.req = 4'b0011;
      tick();
      expect_out("wrap_to_0", 4'b0001, 1'b1, EW'(32'h10));
      tick();
      expect_out("wrap_then_1", 4'b0010, 1'b1, EW'(32'h11));
      tick();
      expect_out("wrap_then_0", 4'b0001, 1'b1, EW'(32'h10));
      bus.req = 4'b1111;
      tick();
      expect_out("wrap_ptr_is_1", 4'b0010, 1'b1, EW'(32'h11));
      bus.req = '0;
      tick();
      expect_out("wrap_drain", 4'b0000, 1'b0, '0);
   endtask

   // rr_ptr is 2 on entry.
   task automatic test_backpressure();
      set_slice(2, EW'(32'hA5));
      bus.req = 4'b0100;
      tick();
      expect_out("bp_capture", 4'b0100, 1'b1, EW'(32'hA5));
      bus.req = '0;
      bus.fifo_push_must_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, EW'(32'hA5));
      end
      expect_cnt("bp_stall_count", 16'h0003);
      bus.fifo_push_must_wait = 1'b0;
      tick();
      expect_out("bp_retire", 4'b0000, 1'b0, '0);
      expect_cnt("bp_count_after_retire", 16'h0003);
   endtask

   // rr_ptr is 3 on entry; flush coincides with an accept.
   task automatic test_flush();
      bus.req = 4'b0100;
      tick();
      expect_out("flush_setup", 4'b0100, 1'b1, EW'(32'hA5));
      bus.flush = 1'b1;
      tick();
      expect_out("flush_drop", 4'b0000, 1'b0, '0);
      bus.flush = 1'b0;
      tick();
      expect_out("flush_regrant", 4'b0100, 1'b1, EW'(32'hA5));
      bus.req = '0;
      tick();
      expect_out("flush_drain", 4'b0000, 1'b0, '0);
   endtask

   // rr_ptr is 3 on entry; reset must bring it back to 0.
   task automatic test_reset_mid_hold();
      bus.req = 4'b1010;
      tick();
      expect_out("rst_setup", 4'b1000, 1'b1, EW'(32'h13));
      bus.fifo_push_must_wait = 1'b1;
      tick();
      RESET = 1'b0;
      #1;
      expect_out("rst_async_outputs", 4'b0000, 1'b0, '0);
      expect_cnt("rst_async_count", 16'h0000);
      tick();
      RESET = 1'b1;
      bus.fifo_push_must_wait = 1'b0;
      tick();
      expect_out("rst_first_grant", 4'b0010, 1'b1, EW'(32'h11));
      bus.req = '0;
      tick();
      expect_out("rst_drain", 4'b0000, 1'b0, '0);
   endtask

   // rr_ptr is 2 on entry, stall_count 0.
   task automatic test_stall_saturation();
      bus.req = 4'b0001;
      tick();
      expect_out("sat_capture", 4'b0001, 1'b1, EW'(32'h10));
      bus.req = '0;
      bus.fifo_push_must_wait = 1'b1;
      repeat (65534) tick();
      expect_cnt("sat_fffe", 16'hFFFE);
      repeat (3) tick();
      expect_cnt("sat_ffff", 16'hFFFF);
      expect_out("sat_still_held", 4'b0000, 1'b1, EW'(32'h10));
      bus.fifo_push_must_wait = 1'b0;
      tick();
      expect_out("sat_retire", 4'b0000, 1'b0, '0);
      expect_cnt("sat_holds", 16'hFFFF);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_ptr_wrap();
      test_backpressure();
      test_flush();
      test_reset_mid_hold();
      test_stall_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
